// File: rtl/tamagotchi_pkg.sv
// tamagotchi_pkg: state encoding and attribute limits shared by the pet controllers.
package tamagotchi_pkg;

    typedef enum logic [4:0] {
        INTRO      = 5'b00000,
        IDLE       = 5'b00001,
        DORMINDO   = 5'b00010,
        COMENDO    = 5'b00100,
        DANDO_AULA = 5'b01000,
        MORTO      = 5'b10000
    } estado_t;

    localparam logic [7:0] MAX_FOME        = 8'd100;
    localparam logic [7:0] MAX_SONO        = 8'd100;
    localparam logic [7:0] MAX_FELICIDADE  = 8'd100;
    localparam logic [7:0] INIT_FOME       = 8'd50;
    localparam logic [7:0] INIT_SONO       = 8'd50;
    localparam logic [7:0] INIT_FELICIDADE = 8'd50;

endpackage

// File: rtl/sincroniza_botao.sv
// sincroniza_botao: 2-FF synchroniser plus registered rising-edge pulse for a raw button.
module sincroniza_botao (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulso
);

    logic [2:0] sinc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sinc_q <= '0;
            pulso  <= 1'b0;
        end else begin
            sinc_q <= {sinc_q[1:0], in};
            pulso  <= sinc_q[1] & ~sinc_q[2];
        end
    end

endmodule

// File: rtl/controlador_estados.sv
// controlador_estados: pet state machine driving the one-hot estado bus and the age counter.
// Define AUTO_DORMIR_EN to let an idle pet fall asleep by itself when sono is low.
module controlador_estados
    import tamagotchi_pkg::*;
#(
    parameter int         TICK_W      = 23,
    parameter int         ATIV_TICKS  = 10,
    parameter int         MORTO_TICKS = 4,
    parameter logic [7:0] LIMIAR_SONO = 8'd10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_dormir,
    input  logic        btn_comer,
    input  logic        btn_aula,
    input  logic [7:0]  fome,
    input  logic [7:0]  felicidade,
    input  logic [7:0]  sono,
    output logic [4:0]  estado,
    output logic [15:0] idade
);

    logic p_start, p_dormir, p_comer, p_aula;
    logic tick, morte, vivo, fim_timer, auto_dormir;
    logic [TICK_W-1:0] tick_q;
    logic [7:0]        timer_q;
    logic [15:0]       idade_q;
    estado_t           estado_q;

    sincroniza_botao u_start  (.clk(clk), .rst(rst), .in(btn_start),  .pulso(p_start));
    sincroniza_botao u_dormir (.clk(clk), .rst(rst), .in(btn_dormir), .pulso(p_dormir));
    sincroniza_botao u_comer  (.clk(clk), .rst(rst), .in(btn_comer),  .pulso(p_comer));
    sincroniza_botao u_aula   (.clk(clk), .rst(rst), .in(btn_aula),   .pulso(p_aula));

    assign tick      = tick_q == '0;
    assign morte     = fome == 8'd0 || felicidade == 8'd0 || sono == 8'd0;
    assign vivo      = estado_q inside {IDLE, DORMINDO, COMENDO, DANDO_AULA};
    assign fim_timer = tick && timer_q <= 8'd1;

`ifdef AUTO_DORMIR_EN
    assign auto_dormir = sono < LIMIAR_SONO && sono != 8'd0;
`else
    logic unused_limiar;
    assign unused_limiar = ^LIMIAR_SONO;
    assign auto_dormir   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q   <= '0;
            timer_q  <= '0;
            idade_q  <= '0;
            estado_q <= INTRO;
        end else begin
            tick_q <= tick_q + TICK_W'(1);
            if (tick && timer_q != 8'd0)
                timer_q <= timer_q - 8'd1;
            if (tick && vivo && idade_q != 16'hFFFF)
                idade_q <= idade_q + 16'd1;
            // Death beats every button and timer event in the same cycle
            if (vivo && morte) begin
                estado_q <= MORTO;
                timer_q  <= 8'(MORTO_TICKS);
            end else begin
                case (estado_q)
                    INTRO:
                        if (p_start && !morte)
                            estado_q <= IDLE;
                    IDLE:
                        if (p_dormir || p_comer || p_aula || auto_dormir) begin
                            estado_q <= p_dormir ? DORMINDO : p_comer ? COMENDO : p_aula ? DANDO_AULA : DORMINDO;
                            timer_q  <= 8'(ATIV_TICKS);
                        end
                    DORMINDO:
                        if (fim_timer || sono >= MAX_SONO || p_dormir)
                            estado_q <= IDLE;
                    COMENDO:
                        if (fim_timer || fome >= MAX_FOME || p_comer)
                            estado_q <= IDLE;
                    DANDO_AULA:
                        if (fim_timer || felicidade >= MAX_FELICIDADE || p_aula)
                            estado_q <= IDLE;
                    MORTO:
                        if (fim_timer) begin
                            estado_q <= INTRO;
                            idade_q  <= '0;
                        end
                    default: begin
                        estado_q <= INTRO;
                        idade_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign estado = estado_q;
    assign idade  = idade_q;

endmodule

// File: tb/tb_controlador_estados.sv
// tb_controlador_estados: vector table plus hand-written timing sequences for controlador_estados.
module tb_controlador_estados;

    localparam int TICK_W = 4, ATIV_TICKS = 3, MORTO_TICKS = 2;
    localparam int PERIODO_TICK = 1 << TICK_W;
    localparam logic [4:0] S_INTRO = 5'b00000, S_IDLE = 5'b00001, S_DORM = 5'b00010,
                           S_COME = 5'b00100, S_AULA = 5'b01000, S_MORTO = 5'b10000;
`ifdef AUTO_DORMIR_EN
    localparam logic [4:0] AUTO_EXP = S_DORM;
`else
    localparam logic [4:0] AUTO_EXP = S_IDLE;
`endif

    logic        clk, rst;
    logic [3:0]  btn;
    logic [7:0]  fome, felicidade, sono;
    logic [4:0]  estado;
    logic [15:0] idade;

    controlador_estados #(.TICK_W(TICK_W), .ATIV_TICKS(ATIV_TICKS), .MORTO_TICKS(MORTO_TICKS)) dut (
        .clk(clk), .rst(rst),
        .btn_start(btn[3]), .btn_dormir(btn[2]), .btn_comer(btn[1]), .btn_aula(btn[0]),
        .fome(fome), .felicidade(felicidade), .sono(sono),
        .estado(estado), .idade(idade)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc, nt, total, bad, t0;
    always @(posedge clk or posedge rst) cyc <= rst ? 0 : cyc + 1;

    typedef struct {
        logic [3:0] btn;
        logic [7:0] f, h, s;
        int         wait_n;
        logic [4:0] exp;
        string      name;
    } vec_t;
    vec_t tbl[16];
    logic [4:0] exp_q[$];
    string      name_q[$];

    function automatic bit is_tick(int n);
        return n >= 1 && ((n - 1) % PERIODO_TICK) == 0;
    endfunction

    task automatic clk1();
        @(posedge clk);
        @(negedge clk);
        if (is_tick(cyc)) nt++;
    endtask

    task automatic clks(int n);
        repeat (n) clk1();
    endtask

    task automatic to_tick_edge();
        while (!is_tick(cyc + 1)) clk1();
    endtask

    task automatic wait_ticks(int base, int n);
        while (nt < base + n) clk1();
    endtask

    task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        total = 0; bad = 0; nt = 0;
        rst = 1'b1; btn = '0; fome = 8'd50; felicidade = 8'd50; sono = 8'd50;
        tbl[0]  = '{4'b0110, 8'd50,  8'd50,  8'd50,  4, S_DORM,  "prio_dormir_comer"};
        tbl[1]  = '{4'b0100, 8'd50,  8'd50,  8'd50,  4, S_IDLE,  "cancel_dormir"};
        tbl[2]  = '{4'b0011, 8'd50,  8'd50,  8'd50,  4, S_COME,  "prio_comer_aula"};
        tbl[3]  = '{4'b0001, 8'd50,  8'd50,  8'd50,  4, S_COME,  "aula_ignored_comendo"};
        tbl[4]  = '{4'b0100, 8'd50,  8'd50,  8'd50,  4, S_COME,  "dormir_ignored_comendo"};
        tbl[5]  = '{4'b0000, 8'd100, 8'd50,  8'd50,  1, S_IDLE,  "fome_full_exit"};
        tbl[6]  = '{4'b0001, 8'd50,  8'd50,  8'd50,  4, S_AULA,  "enter_aula"};
        tbl[7]  = '{4'b1000, 8'd50,  8'd50,  8'd50,  4, S_AULA,  "start_ignored_aula"};
        tbl[8]  = '{4'b0000, 8'd50,  8'd100, 8'd50,  1, S_IDLE,  "felicidade_full_exit"};
        tbl[9]  = '{4'b1000, 8'd50,  8'd50,  8'd50,  4, S_IDLE,  "start_ignored_idle"};
        tbl[10] = '{4'b0100, 8'd50,  8'd50,  8'd50,  4, S_DORM,  "enter_dormir"};
        tbl[11] = '{4'b0000, 8'd50,  8'd50,  8'd100, 1, S_IDLE,  "sono_full_exit"};
        tbl[12] = '{4'b0010, 8'd50,  8'd50,  8'd50,  4, S_COME,  "enter_comer"};
        tbl[13] = '{4'b0010, 8'd50,  8'd50,  8'd50,  4, S_IDLE,  "cancel_comer"};
        tbl[14] = '{4'b0000, 8'd50,  8'd50,  8'd5,   1, AUTO_EXP, "auto_dormir"};
        tbl[15] = '{4'b0000, 8'd50,  8'd50,  8'd100, 1, S_IDLE,  "auto_dormir_exit"};

        repeat (3) @(negedge clk);
        chk("reset_estado", 16'(estado), 16'(S_INTRO));
        chk("reset_idade", idade, 16'd0);
        rst = 1'b0;
        clks(2);
        btn = 4'b1000;
        clks(3);
        chk("start_latency_3clk", 16'(estado), 16'(S_INTRO));
        clk1();
        chk("start_latency_4clk", 16'(estado), 16'(S_IDLE));
        chk("start_idade", idade, 16'd0);
        btn = '0;
        clks(2);

        foreach (tbl[i]) begin
            btn = tbl[i].btn; fome = tbl[i].f; felicidade = tbl[i].h; sono = tbl[i].s;
            exp_q.push_back(tbl[i].exp);
            name_q.push_back(tbl[i].name);
            clks(tbl[i].wait_n);
            chk(name_q.pop_front(), 16'(estado), 16'(exp_q.pop_front()));
            if (btn != '0) begin
                btn = '0;
                clks(2);
            end
        end

        // activity timeout after exactly ATIV_TICKS ticks
        sono = 8'd60; btn = 4'b0100;
        clks(4);
        chk("dormir_enter", 16'(estado), 16'(S_DORM));
        btn = '0; t0 = nt;
        wait_ticks(t0, ATIV_TICKS - 1);
        to_tick_edge();
        chk("dormir_before_last_tick", 16'(estado), 16'(S_DORM));
        clk1();
        chk("dormir_timeout", 16'(estado), 16'(S_IDLE));

        // death wins over an aula cancel pulse in the same cycle
        btn = 4'b0001;
        clks(4);
        chk("aula_enter", 16'(estado), 16'(S_AULA));
        btn = '0;
        clks(2);
        btn = 4'b0001;
        clks(3);
        sono = 8'd0;
        clk1();
        chk("death_over_cancel", 16'(estado), 16'(S_MORTO));
        btn = '0; sono = 8'd60; t0 = nt;
        btn = 4'b1000;
        clks(4);
        chk("morto_ignores_start", 16'(estado), 16'(S_MORTO));
        btn = '0;
        wait_ticks(t0, MORTO_TICKS - 1);
        to_tick_edge();
        chk("morto_before_last_tick", 16'(estado), 16'(S_MORTO));
        clk1();
        chk("morto_to_intro", 16'(estado), 16'(S_INTRO));
        chk("idade_cleared_intro", idade, 16'd0);

        // INTRO refuses start while an attribute is still zero
        fome = 8'd0; sono = 8'd50;
        btn = 4'b1000;
        clks(4);
        chk("start_blocked_fome0", 16'(estado), 16'(S_INTRO));
        btn = '0;
        clks(2);
        fome = 8'd80; btn = 4'b1000;
        clks(4);
        chk("start_fome80", 16'(estado), 16'(S_IDLE));
        btn = '0; t0 = nt;
        wait_ticks(t0, 20);
        chk("idade_20_ticks", idade, 16'd20);

        fome = 8'd0;
        clk1();
        chk("death_in_idle", 16'(estado), 16'(S_MORTO));
        fome = 8'd80; t0 = nt;
        wait_ticks(t0, MORTO_TICKS);
        chk("morto_exit_after_ticks", 16'(estado), 16'(S_INTRO));

        // asynchronous reset in the middle of an activity
        btn = 4'b1000;
        clks(4);
        chk("restart_idle", 16'(estado), 16'(S_IDLE));
        btn = '0;
        clks(2);
        btn = 4'b0100;
        clks(4);
        chk("dormir_before_rst", 16'(estado), 16'(S_DORM));
        btn = '0;
        #2 rst = 1'b1;
        #1 chk("rst_async_estado", 16'(estado), 16'(S_INTRO));
        chk("rst_async_idade", idade, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        clks(2);
        btn = 4'b1000;
        clks(4);
        chk("start_after_rst", 16'(estado), 16'(S_IDLE));
        btn = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
